// File: rtl/med_window_seq.sv
// Window feeder and schedule sequencer for the serial median engine.
// Two line buffers build the 3x3 neighbourhood; each interior pixel launches one 46-cycle median.
module med_window_seq #(
   parameter int N = 7,
   parameter int W = 16,
   parameter int H = 16
) (
   input  logic       CLK,
   input  logic       nRST,
   input  logic [N:0] PIX_IN,
   input  logic       PIX_VALID,
   input  logic       PIX_SOF,
   output logic       PIX_READY,
   output logic [N:0] MED_DI,
   output logic       MED_DSI,
   output logic       MED_BYP,
   input  logic [N:0] MED_DO,
   output logic [N:0] MED_OUT,
   output logic       MED_VALID
);
   localparam int CW = $clog2(W);
   localparam int RW = $clog2(H);
   localparam logic [CW-1:0] COL_LAST = CW'(W - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(H - 1);
   localparam logic [CW-1:0] COL_FIRST_IN = CW'(2);
   localparam logic [RW-1:0] ROW_FIRST_IN = RW'(2);
   localparam logic [5:0] LOAD_LAST = 6'd8;
   localparam logic [5:0] SORT_LAST = 6'd35;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      SORT = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t        state_r;
   logic [5:0]    k_r;
   logic [CW-1:0] col_r;
   logic [RW-1:0] row_r;
   logic [N:0]    lb0_r [W];
   logic [N:0]    lb1_r [W];
   logic [N:0]    win_r [9];
   logic          pix_ready_r;
   logic          med_dsi_r;
   logic          med_byp_r;
   logic          med_valid_r;
   logic [N:0]    med_di_r;
   logic [N:0]    med_out_r;

   logic [N:0]    win_next_s [9];
   logic          accept_s;
   logic          trigger_s;
   logic [CW-1:0] col_s;
   logic [RW-1:0] row_s;
   logic [5:0]    k_inc_s;
   logic [3:0]    ld_idx_s;
   logic          sort_byp_s;

   assign PIX_READY = pix_ready_r;
   assign MED_DI    = med_di_r;
   assign MED_DSI   = med_dsi_r;
   assign MED_BYP   = med_byp_r;
   assign MED_OUT   = med_out_r;
   assign MED_VALID = med_valid_r;

   // Position of the offered pixel (SOF forces 0,0) and the window it would complete.
   always_comb begin
      accept_s  = PIX_VALID && pix_ready_r;
      col_s     = PIX_SOF ? {CW{1'b0}} : col_r;
      row_s     = PIX_SOF ? {RW{1'b0}} : row_r;
      trigger_s = (row_s >= ROW_FIRST_IN) && (col_s >= COL_FIRST_IN);
      for (int r = 0; r < 3; r++) begin
         win_next_s[3*r]   = win_r[3*r+1];
         win_next_s[3*r+1] = win_r[3*r+2];
      end
      win_next_s[2] = lb0_r[col_s];
      win_next_s[5] = lb1_r[col_s];
      win_next_s[8] = PIX_IN;
      k_inc_s    = k_r + 6'd1;
      ld_idx_s   = k_inc_s[3:0];
      sort_byp_s = (k_inc_s == 6'd8) || (k_inc_s == 6'd17) ||
                   (k_inc_s == 6'd26) || (k_inc_s == 6'd35);
   end

   // Line buffers carry no reset: rows >= 2 only read columns already written this frame.
   always_ff @(posedge CLK) begin
      if (accept_s) begin
         lb0_r[col_s] <= lb1_r[col_s];
         lb1_r[col_s] <= PIX_IN;
      end
   end

   // Raster counters and 3x3 window; frozen while a median is in flight.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         col_r <= {CW{1'b0}};
         row_r <= {RW{1'b0}};
         for (int i = 0; i < 9; i++) begin
            win_r[i] <= {(N+1){1'b0}};
         end
      end else if (accept_s) begin
         win_r <= win_next_s;
         if (col_s == COL_LAST) begin
            col_r <= {CW{1'b0}};
            row_r <= (row_s == ROW_LAST) ? {RW{1'b0}} : row_s + RW'(1);
         end else begin
            col_r <= col_s + CW'(1);
            row_r <= row_s;
         end
      end
   end

   // Median schedule FSM; each output register holds the value for the coming cycle.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_r     <= IDLE;
         k_r         <= 6'd0;
         pix_ready_r <= 1'b1;
         med_di_r    <= {(N+1){1'b0}};
         med_dsi_r   <= 1'b0;
         med_byp_r   <= 1'b0;
         med_out_r   <= {(N+1){1'b0}};
         med_valid_r <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               med_valid_r <= 1'b0;
               k_r         <= 6'd0;
               if (accept_s && trigger_s) begin
                  state_r     <= LOAD;
                  pix_ready_r <= 1'b0;
                  med_di_r    <= win_next_s[0];
                  med_dsi_r   <= 1'b1;
                  med_byp_r   <= 1'b1;
               end else begin
                  pix_ready_r <= 1'b1;
                  med_di_r    <= {(N+1){1'b0}};
                  med_dsi_r   <= 1'b0;
                  med_byp_r   <= 1'b0;
               end
            end
            LOAD: begin
               if (k_r == LOAD_LAST) begin
                  state_r   <= SORT;
                  k_r       <= 6'd0;
                  med_di_r  <= {(N+1){1'b0}};
                  med_dsi_r <= 1'b0;
                  med_byp_r <= 1'b0;
               end else begin
                  k_r       <= k_inc_s;
                  med_di_r  <= win_r[ld_idx_s];
                  med_dsi_r <= 1'b1;
                  med_byp_r <= 1'b1;
               end
            end
            SORT: begin
               if (k_r == SORT_LAST) begin
                  state_r     <= DONE;
                  k_r         <= 6'd0;
                  med_byp_r   <= 1'b0;
                  med_out_r   <= MED_DO;
                  med_valid_r <= 1'b1;
               end else begin
                  k_r       <= k_inc_s;
                  med_byp_r <= sort_byp_s;
               end
            end
            DONE: begin
               state_r     <= IDLE;
               med_valid_r <= 1'b0;
               pix_ready_r <= 1'b1;
            end
            default: begin
               state_r     <= IDLE;
               k_r         <= 6'd0;
               pix_ready_r <= 1'b1;
               med_di_r    <= {(N+1){1'b0}};
               med_dsi_r   <= 1'b0;
               med_byp_r   <= 1'b0;
               med_valid_r <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_med_window_seq.sv
// Bench for med_window_seq: three instances (3x3, 16x16, 4x4) each driving a behavioural
// median engine that captures the nine DSI-qualified samples and presents their median.
module tb_med_window_seq;

   typedef struct {
      logic [7:0] pix;
      logic       sof;
      logic       trig;
      logic [7:0] med;
   } vec_t;

   localparam logic [35:0] BYP_EXP = 36'h8_0402_0100;

   logic       clk;
   logic       nrst;
   logic [7:0] pix_in    [3];
   logic       pix_valid [3];
   logic       pix_sof   [3];
   logic       pix_ready [3];
   logic [7:0] med_di    [3];
   logic       med_dsi   [3];
   logic       med_byp   [3];
   logic [7:0] med_do    [3];
   logic [7:0] med_out   [3];
   logic       med_valid [3];

   logic [7:0]  ld [3][9];
   int          cyc = 0;
   int          strobe_cnt [3] = '{0, 0, 0};
   int          last_cyc   [3] = '{0, 0, 0};
   int          load_err   [3] = '{0, 0, 0};
   int          sort_err   [3] = '{0, 0, 0};
   int          sc         [3] = '{36, 36, 36};
   logic [7:0]  last_val   [3];
   logic [35:0] byp_mask   [3];
   int          passed = 0;
   int          total = 0;

   vec_t tab3 [9];
   vec_t tab4 [16];
   logic [7:0] med4 [4];

   med_window_seq #(.N(7), .W(3), .H(3)) u_dut3 (
      .CLK(clk), .nRST(nrst), .PIX_IN(pix_in[0]), .PIX_VALID(pix_valid[0]), .PIX_SOF(pix_sof[0]),
      .PIX_READY(pix_ready[0]), .MED_DI(med_di[0]), .MED_DSI(med_dsi[0]), .MED_BYP(med_byp[0]),
      .MED_DO(med_do[0]), .MED_OUT(med_out[0]), .MED_VALID(med_valid[0]));

   med_window_seq #(.N(7), .W(16), .H(16)) u_dut16 (
      .CLK(clk), .nRST(nrst), .PIX_IN(pix_in[1]), .PIX_VALID(pix_valid[1]), .PIX_SOF(pix_sof[1]),
      .PIX_READY(pix_ready[1]), .MED_DI(med_di[1]), .MED_DSI(med_dsi[1]), .MED_BYP(med_byp[1]),
      .MED_DO(med_do[1]), .MED_OUT(med_out[1]), .MED_VALID(med_valid[1]));

   med_window_seq #(.N(7), .W(4), .H(4)) u_dut4 (
      .CLK(clk), .nRST(nrst), .PIX_IN(pix_in[2]), .PIX_VALID(pix_valid[2]), .PIX_SOF(pix_sof[2]),
      .PIX_READY(pix_ready[2]), .MED_DI(med_di[2]), .MED_DSI(med_dsi[2]), .MED_BYP(med_byp[2]),
      .MED_DO(med_do[2]), .MED_OUT(med_out[2]), .MED_VALID(med_valid[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [7:0] med9(input logic [7:0] v [9]);
      logic [7:0] s [9];
      logic [7:0] t;
      s = v;
      for (int a = 0; a < 8; a++) begin
         for (int b = 0; b < 8 - a; b++) begin
            if (s[b] > s[b+1]) begin
               t = s[b];
               s[b] = s[b+1];
               s[b+1] = t;
            end
         end
      end
      return s[4];
   endfunction

   // Behavioural median engine: shift in DI while DSI, present the median of the nine.
   always @(posedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (med_dsi[i]) begin
            for (int k = 0; k < 8; k++) ld[i][k] <= ld[i][k+1];
            ld[i][8] <= med_di[i];
         end
      end
   end

   always_comb begin
      for (int i = 0; i < 3; i++) med_do[i] = med9(ld[i]);
   end

   // Strobe recorder and LOAD/SORT control-pattern tracker.
   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (med_valid[i]) begin
            strobe_cnt[i] <= strobe_cnt[i] + 1;
            last_val[i]   <= med_out[i];
            last_cyc[i]   <= cyc;
         end
         if (med_dsi[i]) begin
            sc[i]       <= 0;
            byp_mask[i] <= 36'd0;
            if (!med_byp[i]) load_err[i] <= load_err[i] + 1;
         end else if (sc[i] < 36) begin
            byp_mask[i][sc[i]] <= med_byp[i];
            if (med_di[i] != 8'd0) sort_err[i] <= sort_err[i] + 1;
            sc[i] <= sc[i] + 1;
         end
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end else begin
         passed++;
      end
   endtask

   // Offer one pixel (garbage on PIX_IN while not ready, VALID held high) and, for a
   // triggering pixel, follow the median through to its strobe.
   task automatic drive(input int i, input logic [7:0] p, input logic sof,
                        input logic trig, input logic [7:0] med, input string tag);
      int n;
      int a;
      int c0;
      n = 0;
      pix_valid[i] = 1'b1;
      pix_sof[i]   = sof;
      pix_in[i]    = ~p;
      while (pix_ready[i] !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) begin
         check({tag, " accept_timeout"}, 64'd0, 64'd1);
         return;
      end
      pix_in[i] = p;
      c0 = strobe_cnt[i];
      @(negedge clk);
      a = cyc;
      check({tag, " ready_after_accept"}, pix_ready[i], !trig);
      if (trig) begin
         pix_in[i] = ~p;
         n = 0;
         while (pix_ready[i] !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
         end
         check({tag, " busy_cycles"}, n, 46);
         check({tag, " strobe_count"}, strobe_cnt[i], c0 + 1);
         check({tag, " latency"}, last_cyc[i] - a, 45);
         check({tag, " median"}, last_val[i], med);
      end
   endtask

   task automatic idle(input int i);
      pix_valid[i] = 1'b0;
      pix_sof[i]   = 1'b0;
      pix_in[i]    = 8'd0;
   endtask

   initial begin
      int c0;
      int r;
      int c;
      tab3[0] = '{8'd9, 1'b1, 1'b0, 8'd0};
      tab3[1] = '{8'd1, 1'b0, 1'b0, 8'd0};
      tab3[2] = '{8'd8, 1'b0, 1'b0, 8'd0};
      tab3[3] = '{8'd2, 1'b0, 1'b0, 8'd0};
      tab3[4] = '{8'd7, 1'b0, 1'b0, 8'd0};
      tab3[5] = '{8'd3, 1'b0, 1'b0, 8'd0};
      tab3[6] = '{8'd6, 1'b0, 1'b0, 8'd0};
      tab3[7] = '{8'd4, 1'b0, 1'b0, 8'd0};
      tab3[8] = '{8'd5, 1'b0, 1'b1, 8'd5};
      med4[0] = 8'd5;
      med4[1] = 8'd6;
      med4[2] = 8'd9;
      med4[3] = 8'd10;
      c = 0;
      for (int k = 0; k < 16; k++) begin
         tab4[k].pix  = 8'(k);
         tab4[k].sof  = (k == 0);
         tab4[k].trig = ((k / 4) >= 2) && ((k % 4) >= 2);
         tab4[k].med  = tab4[k].trig ? med4[c] : 8'd0;
         if (tab4[k].trig) c++;
      end

      nrst = 1'b0;
      for (int i = 0; i < 3; i++) idle(i);
      repeat (3) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         check("reset pix_ready", pix_ready[i], 1'b1);
         check("reset med_dsi", med_dsi[i], 1'b0);
         check("reset med_byp", med_byp[i], 1'b0);
         check("reset med_di", med_di[i], 8'd0);
         check("reset med_out", med_out[i], 8'd0);
         check("reset med_valid", med_valid[i], 1'b0);
      end
      nrst = 1'b1;
      @(negedge clk);

      // 3x3 frame: one median, LOAD order checked through the engine model.
      for (int k = 0; k < 9; k++) drive(0, tab3[k].pix, tab3[k].sof, tab3[k].trig, tab3[k].med, "w3");
      idle(0);
      for (int k = 0; k < 9; k++) check("w3 load_order", ld[0][k], tab3[k].pix);
      check("w3 load_dsi_byp", load_err[0], 0);
      check("w3 sort_di_zero", sort_err[0], 0);
      check("w3 byp_pattern", byp_mask[0], BYP_EXP);
      repeat (5) @(negedge clk);
      check("w3 out_hold", med_out[0], 8'd5);
      check("w3 valid_low", med_valid[0], 1'b0);

      // Reset mid-SORT: immediate abort, no strobe afterwards.
      for (int k = 0; k < 8; k++) drive(0, tab3[k].pix, tab3[k].sof, 1'b0, 8'd0, "rst");
      pix_in[0] = tab3[8].pix;
      @(negedge clk);
      idle(0);
      c0 = strobe_cnt[0];
      repeat (20) @(negedge clk);
      check("rst busy_before", pix_ready[0], 1'b0);
      check("rst in_sort", med_dsi[0], 1'b0);
      #2 nrst = 1'b0;
      #1;
      check("rst async pix_ready", pix_ready[0], 1'b1);
      check("rst async med_dsi", med_dsi[0], 1'b0);
      check("rst async med_byp", med_byp[0], 1'b0);
      check("rst async med_di", med_di[0], 8'd0);
      check("rst async med_out", med_out[0], 8'd0);
      check("rst async med_valid", med_valid[0], 1'b0);
      @(negedge clk);
      nrst = 1'b1;
      repeat (60) @(negedge clk);
      check("rst no_strobe", strobe_cnt[0], c0);
      check("rst ready_after", pix_ready[0], 1'b1);

      // 4x4 ramp with VALID held high throughout (backpressure).
      for (int k = 0; k < 16; k++) drive(2, tab4[k].pix, tab4[k].sof, tab4[k].trig, tab4[k].med, "w4");
      check("w4 byp_pattern", byp_mask[2], BYP_EXP);
      check("w4 load_dsi_byp", load_err[2], 0);
      check("w4 sort_di_zero", sort_err[2], 0);

      // Frame cut short at (1,3) by a new SOF; triggers must follow the new frame.
      for (int k = 0; k < 7; k++) drive(2, 8'(50 + k), k == 0, 1'b0, 8'd0, "sof_old");
      for (int k = 0; k < 16; k++)
         drive(2, 8'(100 + k), tab4[k].sof, tab4[k].trig, 8'(100) + tab4[k].med, "sof_new");
      idle(2);

      // 16x16 constant frame.
      c0 = strobe_cnt[1];
      for (int k = 0; k < 256; k++) begin
         r = k / 16;
         c = k % 16;
         drive(1, 8'hA5, k == 0, (r >= 2) && (c >= 2), 8'hA5, "w16");
      end
      idle(1);
      repeat (3) @(negedge clk);
      check("w16 strobe_total", strobe_cnt[1] - c0, 196);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
